acc_feeder: RTL and testbench

//  Upstream framing stage for the 128-bit serial accumulator (acc).

---
 rtl/acc_feeder_if.sv | 26 ++
 rtl/acc_feeder.sv | 153 +++++++++++++++
 tb/tb_acc_feeder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_feeder_if.sv
// Host-side entry handshake and accumulator-side serial outputs of acc_feeder.
// The producer uses the master modport and the feeder uses the slave modport.
interface acc_feeder_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic                     in_clear;
    logic                     add;
    logic                     rx;
    logic                     clear;
    logic                     busy;
    logic [$clog2(DEPTH):0]   fifo_level;

    modport master (
        output in_valid, in_data, in_clear,
        input  in_ready, add, rx, clear, busy, fifo_level
    );

    modport slave (
        input  in_valid, in_data, in_clear,
        output in_ready, add, rx, clear, busy, fifo_level
    );
endinterface

// File: rtl/acc_feeder.sv
// Buffers host words and clear commands in a small FIFO, then replays each one
// to the serial accumulator as a start bit, WIDTH bits MSB first and an idle gap.
module acc_feeder #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int CLR_CYCLES = 1
) (
    input logic         clk,
    input logic         rst,
    acc_feeder_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int MAXC = (WIDTH > GAP_CYCLES)
                        ? ((WIDTH > CLR_CYCLES) ? WIDTH : CLR_CYCLES)
                        : ((GAP_CYCLES > CLR_CYCLES) ? GAP_CYCLES : CLR_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, START, SHIFT, GAP, CLR} state_t;

    // FIFO storage: one entry is {clear flag, data word}
    logic [WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic             full, empty, push, pop;
    logic [WIDTH:0]   head;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] sh, sh_d;
    logic             add_q, rx_q, clear_q;
    logic             add_d, rx_d, clear_d;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign push  = bus.in_valid && !full;
    assign head  = mem[rd_ptr];

    // NOTE: the storage array has no reset; emptiness is defined by level and
    // the pointers alone, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_clear, bus.in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: add/rx/clear are decoded from the *next* state so the registered
    // outputs line up exactly with the state they describe.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sh_d    = sh;
        add_d   = 1'b0;
        rx_d    = 1'b1;
        clear_d = 1'b0;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    cnt_d = '0;
                    if (head[WIDTH]) begin
                        state_d = CLR;
                        clear_d = 1'b1;
                    end else begin
                        state_d = START;
                        add_d   = 1'b1;
                        rx_d    = 1'b0;
                        sh_d    = head[WIDTH-1:0];
                    end
                end
            end
            START: begin
                state_d = SHIFT;
                cnt_d   = '0;
                add_d   = 1'b1;
                rx_d    = sh[WIDTH-1];
                sh_d    = {sh[WIDTH-2:0], 1'b0};
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                    add_d = 1'b1;
                    rx_d  = sh[WIDTH-1];
                    sh_d  = {sh[WIDTH-2:0], 1'b0};
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            CLR: begin
                if (cnt == CW'(CLR_CYCLES - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt + 1'b1;
                    clear_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sh      <= '0;
            add_q   <= 1'b0;
            rx_q    <= 1'b1;
            clear_q <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            sh      <= sh_d;
            add_q   <= add_d;
            rx_q    <= rx_d;
            clear_q <= clear_d;
        end
    end

    assign bus.in_ready   = !full;
    assign bus.add        = add_q;
    assign bus.rx         = rx_q;
    assign bus.clear      = clear_q;
    assign bus.busy       = (state != IDLE) || !empty;
    assign bus.fifo_level = level;
endmodule

// File: tb/tb_acc_feeder.sv
// Self-checking bench for acc_feeder: a driver pushes entries into a scoreboard,
// a negedge monitor deserializes frames/clears and checks them in order.
module tb_acc_feeder;
    localparam int WIDTH      = 32;
    localparam int DEPTH      = 4;
    localparam int GAP_CYCLES = 2;
    localparam int CLR_CYCLES = 1;
    localparam int PERIOD     = 1 + 1 + WIDTH + GAP_CYCLES;

    typedef struct packed {
        logic             is_clear;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    acc_feeder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    acc_feeder #(
        .WIDTH(WIDTH), .DEPTH(DEPTH),
        .GAP_CYCLES(GAP_CYCLES), .CLR_CYCLES(CLR_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    entry_t           sb[$];
    int               rises[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [127:0]     exp_acc = '0;
    logic [127:0]     obs_acc = '0;
    int               cyc = 0;
    bit               saw_full = 0;

    bit               in_frame = 0;
    bit               in_clr = 0;
    bit               have_prev = 0;
    int               nbits = 0;
    int               clen = 0;
    int               gap = 0;
    logic [WIDTH-1:0] shreg = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Retire one observed item against the oldest accepted entry.
    task automatic finish_item(input bit is_clr, input logic [WIDTH-1:0] val);
        entry_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_item: got clear=%0d data=%0h expected nothing", is_clr, val);
        end else begin
            e = sb.pop_front();
            check("item_kind", is_clr, e.is_clear);
            if (!is_clr && !e.is_clear) check("frame_data", val, e.data);
        end
        if (is_clr) obs_acc = '0;
        else        obs_acc = obs_acc + val;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame  = 0;
            in_clr    = 0;
            have_prev = 0;
        end else begin
            check("add_clear_excl", bus.add & bus.clear, 0);
            check("level_bound", bus.fifo_level > DEPTH, 0);
            if (bus.fifo_level == DEPTH && !bus.in_ready) saw_full = 1;
            if (!bus.add) check("rx_idle_high", bus.rx, 1);

            if (bus.add && !in_frame) begin
                if (have_prev) check("gap_min", gap >= GAP_CYCLES + 1, 1);
                check("start_bit", bus.rx, 0);
                in_frame = 1;
                nbits    = 0;
                shreg    = '0;
                rises.push_back(cyc);
            end else if (bus.add && in_frame) begin
                if (nbits < WIDTH) begin
                    shreg = {shreg[WIDTH-2:0], bus.rx};
                    nbits++;
                end else begin
                    check("add_len", nbits + 1, WIDTH);
                end
            end else if (!bus.add && in_frame) begin
                in_frame = 0;
                check("frame_bits", nbits, WIDTH);
                finish_item(0, shreg);
                have_prev = 1;
                gap       = 0;
            end

            if (bus.clear && !in_clr) begin
                if (have_prev) check("gap_min", gap >= GAP_CYCLES + 1, 1);
                in_clr = 1;
                clen   = 1;
            end else if (bus.clear) begin
                clen++;
            end else if (in_clr) begin
                in_clr = 0;
                check("clear_len", clen, CLR_CYCLES);
                finish_item(1, '0);
                have_prev = 1;
                gap       = 0;
            end

            if (!bus.add && !bus.clear) gap++;
        end
    end

    task automatic push_entry(input logic clr, input logic [WIDTH-1:0] d);
        int waited = 0;
        entry_t e;
        bus.in_valid = 1'b1;
        bus.in_clear = clr;
        bus.in_data  = d;
        while (!bus.in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 1000) begin
            check("push_timeout", waited, 0);
        end else begin
            e.is_clear = clr;
            e.data     = d;
            sb.push_back(e);
            if (clr) exp_acc = '0;
            else     exp_acc = exp_acc + d;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || bus.busy || in_frame || in_clr) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, n < 5000, 1);
        repeat (GAP_CYCLES + 2) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        sb.delete();
        exp_acc = '0;
        obs_acc = '0;
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int n;
        logic [WIDTH-1:0] d;

        bus.in_valid = 1'b0;
        bus.in_clear = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_add", bus.add, 0);
        check("rst_rx", bus.rx, 1);
        check("rst_clear", bus.clear, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_level", bus.fifo_level, 0);
        check("rst_in_ready", bus.in_ready, 1);
        #1 rst = 1'b0;
        @(negedge clk);

        // 1: single word
        base = rises.size();
        push_entry(0, 32'h0000_0001);
        check("t1_busy", bus.busy, 1);
        wait_drain("t1");
        check("t1_frames", rises.size() - base, 1);
        check("t1_acc", obs_acc, 128'd1);

        // 2: ten back-to-back words, FIFO fills, fixed frame period
        do_reset();
        saw_full = 0;
        base = rises.size();
        for (int i = 0; i < 10; i++) push_entry(0, 32'h0000_0001);
        wait_drain("t2");
        check("t2_frames", rises.size() - base, 10);
        for (int i = 1; i < 10; i++)
            if (base + i < rises.size())
                check("t2_period", rises[base+i] - rises[base+i-1], PERIOD);
        check("t2_saw_full", saw_full, 1);
        check("t2_acc", obs_acc, 128'd10);

        // 3: word, clear, word
        do_reset();
        push_entry(0, 32'h1000_0000);
        push_entry(1, '0);
        push_entry(0, 32'h0000_0003);
        wait_drain("t3");
        check("t3_acc", obs_acc, 128'd3);

        // 4: fill to DEPTH, then keep pushing across pops while full
        do_reset();
        for (int i = 1; i <= 5; i++) push_entry(0, WIDTH'(i * 32'h11));
        check("t4_level_full", bus.fifo_level, DEPTH);
        check("t4_ready_low", bus.in_ready, 0);
        push_entry(0, 32'h66);
        push_entry(0, 32'h77);
        wait_drain("t4");
        check("t4_acc", obs_acc, 128'h11 + 128'h22 + 128'h33 + 128'h44 + 128'h55 + 128'h66 + 128'h77);

        // 5: reset during SHIFT of the second frame
        do_reset();
        base = rises.size();
        push_entry(0, 32'h1234_5678);
        push_entry(0, 32'h0F0F_0F0F);
        n = 0;
        while (rises.size() < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_second_frame", rises.size() - base, 2);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_add", bus.add, 0);
        check("t5_rst_rx", bus.rx, 1);
        check("t5_rst_level", bus.fifo_level, 0);
        check("t5_rst_busy", bus.busy, 0);
        @(negedge clk);
        sb.delete();
        exp_acc = '0;
        obs_acc = '0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        base = rises.size();
        push_entry(0, 32'h0000_00A5);
        wait_drain("t5");
        check("t5_frames", rises.size() - base, 1);
        check("t5_acc", obs_acc, 128'hA5);

        // 6: all-ones words
        do_reset();
        for (int i = 0; i < 5; i++) push_entry(0, 32'hFFFF_FFFF);
        wait_drain("t6");
        check("t6_acc", obs_acc, 128'd5 * 128'hFFFF_FFFF);

        // 7: random words and clears with random idle spacing
        do_reset();
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            push_entry($urandom_range(0, 7) == 0, d);
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_drain("t7");
        check("t7_acc", obs_acc, exp_acc);
        check("t7_idle_level", bus.fifo_level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
